pipe_addsub: RTL
================

Name: pipe_addsub

Overview:
Parametrised, pipelined adder/subtractor that splits a WIDTH-bit add into SEG_W-bit ripple segments, one segment per pipeline stage. It carries the inter-segment carry through registers and presents a valid/ready stream interface on both sides. It is the datapath arithmetic core that the ALU instantiates for ADD/SUB/SLT, replacing single-bit combinational adder chains. Result flags are cout, signed overflow and zero.

Parameters:
WIDTH, 32, operand/result width in bits; must be a multiple of SEG_W.
SEG_W, 8, bits added per pipeline stage; STAGES = WIDTH/SEG_W (derived localparam, >=1).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous, active-low reset
in_valid  input  1  operand beat valid
in_ready  output  1  block accepts a beat this cycle
src1  input  WIDTH  operand A
src2  input  WIDTH  operand B
cin  input  1  carry-in (add) / borrow-in (sub)
sub  input  1  0: src1+src2+cin; 1: src1-src2-cin
out_valid  output  1  result beat valid
out_ready  input  1  downstream accepts result
result  output  WIDTH  sum/difference
cout  output  1  raw carry out of MSB (sub: 1 = no borrow)
overflow  output  1  signed two's-complement overflow
zero  output  1  result == 0

Behaviour:
- Reset: asynchronous on rst_n low; all stage valid bits, out_valid, result, cout, overflow, zero -> 0 immediately; in_ready -> 1 after reset release.
- Operand prep at input: B' = sub ? ~src2 : src2; c0 = sub ? ~cin : cin. Then sub computes src1 + ~src2 + !cin = src1 - src2 - cin.
- Stage k (0..STAGES-1) adds segment k of A and B' with the carry registered by stage k-1 (stage 0 uses c0). It registers its SEG_W sum bits and carry-out.
- Unconsumed upper operand segments and completed lower result segments travel in skew registers alongside, so each beat stays aligned.
- Latency: a beat accepted at edge N appears with out_valid=1 after edge N+STAGES-1, i.e. STAGES register stages total. Throughput is 1 beat/cycle.
- Flags are formed in the last stage from the final segment. cout = carry out of bit WIDTH-1. overflow = carry into MSB XOR carry out of MSB. zero = NOR of the full assembled result.
- Handshake: stall = out_valid & ~out_ready; in_ready = ~stall. A transfer occurs when valid & ready are both high on an edge.
- During stall, every stage register, including bubbles, holds its value. No beat is dropped, duplicated or reordered.
- While out_valid=1 & out_ready=0, result/cout/overflow/zero stay stable.
- Bubbles: in_valid=0 while in_ready=1 inserts an invalid slot. Invalid slots advance normally and never raise out_valid.
- Simultaneous output pop and input push on the same edge are both accepted (full-rate streaming).
- STAGES=1 degenerates to a single registered WIDTH-bit adder with the same handshake.

Optional Feature:
Macro PIPE_ADDSUB_FLUSH_EN.
- Defined: adds input port flush (1 bit). flush=1 on an edge clears all stage valid bits and out_valid synchronously; data regs are don't-care. flush has priority over stall and over a simultaneous input push, so that beat is discarded. in_ready stays 1.
- Undefined: no flush port; the pipeline drains only via handshake.

Decomposition:
- Shared package/header holds the ALU op encodings that drive sub (ADD=0, SUB=1) and the WIDTH default.
- Natural sub-module: seg_adder, a combinational SEG_W-bit ripple adder (a, b, ci -> s, co, c_msb_in) built from single-bit full-adder cells. It is instantiated once per stage; c_msb_in is used only by the last stage for overflow.
- Stage registers and handshake stay in pipe_addsub.

Test Plan:
Bench uses WIDTH=32, SEG_W=8, so latency is 4.
1. 0x000000FF + 0x00000001, cin=0, sub=0 -> 4 cycles later result=0x00000100, cout=0, overflow=0, zero=0 (carry crosses segment 0->1).
2. 0x7FFFFFFF + 0x00000001 -> result=0x80000000, overflow=1, cout=0. Then 0xFFFFFFFF + 0x00000001 -> result=0, cout=1, overflow=0, zero=1.
3. sub=1: 5-7, cin=0 -> 0xFFFFFFFE, cout=0. Then 5-5 -> 0, zero=1, cout=1. Then 0x80000000-1 -> 0x7FFFFFFF, overflow=1. Then 10-3 with cin=1 -> 6.
4. Stream 8 back-to-back beats (i + 0x100*i, i=0..7), out_ready low for 4 cycles mid-stream -> in_ready low exactly while stalled, outputs stable during stall, all 8 results correct and in order.
5. Drop rst_n asynchronously (between edges) with 3 beats in flight -> out_valid=0 and flags=0 immediately. After release, no stale beat appears and a new beat emerges 4 cycles after acceptance.
6. (PIPE_ADDSUB_FLUSH_EN) 3 beats in flight, flush=1 for 1 cycle together with in_valid=1 -> no out_valid for any of the 4 beats. The next beat returns with latency 4.

Source files
------------

// File: rtl/pipe_addsub_pkg.sv
// -----------------------------------------------------------------------------
// pipe_addsub_pkg
// Shared definitions for the pipelined adder/subtractor:
//   - ALU operation encodings that drive the 'sub' control (ADD=0, SUB=1)
//   - default operand width and segment width
//   - helper that turns the carry/borrow input into the segment-0 carry
// No ports (package).
// -----------------------------------------------------------------------------
package pipe_addsub_pkg;

  localparam int ADDSUB_WIDTH = 32;
  localparam int ADDSUB_SEG_W = 8;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } addsub_op_e;

  // Segment-0 carry: add passes cin through; subtract uses !borrow_in so that
  // a + ~b + !cin == a - b - cin.
  function automatic logic first_carry(input logic sub_op, input logic cin_bit);
    logic c_s;
    if (sub_op == OP_SUB) begin
      c_s = ~cin_bit;
    end else begin
      c_s = cin_bit;
    end
    return c_s;
  endfunction

endpackage

// File: rtl/pipe_addsub_seg_adder.sv
// -----------------------------------------------------------------------------
// seg_adder
// Combinational SEG_W-bit ripple-carry adder built from single-bit full-adder
// cells. One instance serves each pipeline stage of pipe_addsub.
// Ports:
//   a, b      [SEG_W-1:0] in   segment operands (b already inverted for sub)
//   ci                    in   carry into bit 0
//   s         [SEG_W-1:0] out  segment sum
//   co                    out  carry out of the segment MSB
//   c_msb_in              out  carry into the segment MSB (overflow detect)
// -----------------------------------------------------------------------------
module seg_adder
  import pipe_addsub_pkg::*;
#(
  parameter int SEG_W = ADDSUB_SEG_W
) (
  input  logic [SEG_W-1:0] a,
  input  logic [SEG_W-1:0] b,
  input  logic             ci,
  output logic [SEG_W-1:0] s,
  output logic             co,
  output logic             c_msb_in
);

  // c_s[i] is the carry into bit i; c_s[SEG_W] leaves the segment.
  logic [SEG_W:0] c_s;

  assign c_s[0] = ci;

  for (genvar i = 0; i < SEG_W; i++) begin : g_fa
    assign s[i]       = a[i] ^ b[i] ^ c_s[i];
    assign c_s[i + 1] = (a[i] & b[i]) | (c_s[i] & (a[i] ^ b[i]));
  end

  assign co       = c_s[SEG_W];
  assign c_msb_in = c_s[SEG_W - 1];

endmodule

// File: rtl/pipe_addsub.sv
// -----------------------------------------------------------------------------
// pipe_addsub
// Pipelined adder/subtractor. A WIDTH-bit add is split into STAGES=WIDTH/SEG_W
// ripple segments, one per register stage; the inter-segment carry is
// registered between stages. Valid/ready stream on both sides, latency STAGES
// register stages, throughput one beat per cycle.
//
// Optional build macro: PIPE_ADDSUB_FLUSH_EN adds a 'flush' input that clears
// every in-flight beat (and a beat pushed on the same edge).
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   flush      in   (PIPE_ADDSUB_FLUSH_EN only) discard all in-flight beats
//   in_valid   in   operand beat valid
//   in_ready   out  beat accepted this cycle when in_valid is high
//   src1, src2 in   operands A, B (WIDTH bits)
//   cin        in   carry-in (add) / borrow-in (sub)
//   sub        in   0: src1+src2+cin, 1: src1-src2-cin
//   out_valid  out  result beat valid
//   out_ready  in   downstream accepts the result beat
//   result     out  sum / difference (WIDTH bits)
//   cout       out  carry out of the MSB (sub: 1 = no borrow)
//   overflow   out  signed two's-complement overflow
//   zero       out  result == 0
// -----------------------------------------------------------------------------
module pipe_addsub
  import pipe_addsub_pkg::*;
#(
  parameter int WIDTH = ADDSUB_WIDTH,
  parameter int SEG_W = ADDSUB_SEG_W
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef PIPE_ADDSUB_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int STAGES = WIDTH / SEG_W;

  // B operand as fed to the adder chain: inverted for subtract.
  function automatic logic [WIDTH-1:0] prep_b(input logic [WIDTH-1:0] b_val,
                                              input logic             sub_op);
    logic [WIDTH-1:0] r_s;
    if (sub_op == OP_SUB) begin
      r_s = ~b_val;
    end else begin
      r_s = b_val;
    end
    return r_s;
  endfunction

  // Per-stage inputs (stage 0 from the ports, stage k from stage k-1 regs).
  // Operands are kept right-aligned: the segment a stage consumes is always
  // in bits [SEG_W-1:0], and each stage shifts the remainder down by SEG_W.
  // Partial results enter at the top and shift down, so after the last stage
  // the whole result sits in its natural position.
  logic [WIDTH-1:0] a_in_s   [STAGES];
  logic [WIDTH-1:0] b_in_s   [STAGES];
  logic [WIDTH-1:0] sum_in_s [STAGES];
  logic             c_in_s   [STAGES];
  logic             vld_in_s [STAGES];

  // Segment adder outputs and the next partial result per stage.
  logic [SEG_W-1:0] seg_s     [STAGES];
  logic             co_s      [STAGES];
  logic             cm_s      [STAGES];
  logic [WIDTH-1:0] sum_nxt_s [STAGES];

  // Stage registers.
  logic [WIDTH-1:0] a_r   [STAGES];
  logic [WIDTH-1:0] b_r   [STAGES];
  logic [WIDTH-1:0] sum_r [STAGES];
  logic             c_r   [STAGES];
  logic             vld_r [STAGES];
  logic             ovf_r;
  logic             zero_r;

  logic             stall_s;
  logic             flush_s;

`ifdef PIPE_ADDSUB_FLUSH_EN
  assign flush_s = flush;
`else
  assign flush_s = 1'b0;
`endif

  // The whole pipe freezes while the output beat is held by the consumer;
  // a flush overrides the freeze so the input side never blocks during it.
  assign stall_s  = vld_r[STAGES-1] & ~out_ready;
  assign in_ready = ~stall_s | flush_s;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign a_in_s[k]   = src1;
      assign b_in_s[k]   = prep_b(src2, sub);
      assign c_in_s[k]   = first_carry(sub, cin);
      assign sum_in_s[k] = {WIDTH{1'b0}};
      assign vld_in_s[k] = in_valid;
    end else begin : g_next
      assign a_in_s[k]   = a_r[k-1];
      assign b_in_s[k]   = b_r[k-1];
      assign c_in_s[k]   = c_r[k-1];
      assign sum_in_s[k] = sum_r[k-1];
      assign vld_in_s[k] = vld_r[k-1];
    end

    seg_adder #(
      .SEG_W (SEG_W)
    ) u_seg (
      .a        (a_in_s[k][SEG_W-1:0]),
      .b        (b_in_s[k][SEG_W-1:0]),
      .ci       (c_in_s[k]),
      .s        (seg_s[k]),
      .co       (co_s[k]),
      .c_msb_in (cm_s[k])
    );

    // New segment enters at the top; earlier segments move down by SEG_W.
    assign sum_nxt_s[k] = (sum_in_s[k] >> SEG_W) | (WIDTH'(seg_s[k]) << (WIDTH - SEG_W));
  end

  // Stage registers: valid bits, operand skew, partial results, carries, flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_r[k] <= 1'b0;
        a_r[k]   <= {WIDTH{1'b0}};
        b_r[k]   <= {WIDTH{1'b0}};
        sum_r[k] <= {WIDTH{1'b0}};
        c_r[k]   <= 1'b0;
      end
      ovf_r  <= 1'b0;
      zero_r <= 1'b0;
    end else if (flush_s) begin
      // Data registers are don't-care once their valid bits are cleared.
      for (int k = 0; k < STAGES; k++) begin
        vld_r[k] <= 1'b0;
      end
    end else if (!stall_s) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_r[k] <= vld_in_s[k];
        a_r[k]   <= a_in_s[k] >> SEG_W;
        b_r[k]   <= b_in_s[k] >> SEG_W;
        sum_r[k] <= sum_nxt_s[k];
        c_r[k]   <= co_s[k];
      end
      // Flags come from the final segment only.
      ovf_r  <= co_s[STAGES-1] ^ cm_s[STAGES-1];
      zero_r <= ~|sum_nxt_s[STAGES-1];
    end else begin
      // Stalled: every stage, bubbles included, holds.
      ovf_r  <= ovf_r;
      zero_r <= zero_r;
    end
  end

  // The last stage register is the output register.
  assign out_valid = vld_r[STAGES-1];
  assign result    = sum_r[STAGES-1];
  assign cout      = c_r[STAGES-1];
  assign overflow  = ovf_r;
  assign zero      = zero_r;

endmodule
